// File: rtl/geofence_xarb_if.sv
// Request/operand/result bundle between the two geofence requesters and the arbitrated cross-product unit.
// The res_zero flag exists only when GEOFENCE_XARB_ZERO_FLAG_EN is defined.
interface geofence_xarb_if;
  logic               req0;
  logic               req1;
  logic               lock0;
  logic               lock1;
  logic signed [10:0] ax0;
  logic signed [10:0] ay0;
  logic signed [10:0] bx0;
  logic signed [10:0] by0;
  logic signed [10:0] ax1;
  logic signed [10:0] ay1;
  logic signed [10:0] bx1;
  logic signed [10:0] by1;
  logic               gnt0;
  logic               gnt1;
  logic               res_valid;
  logic               res_id;
  logic signed [22:0] res_value;
  logic               res_pos;
`ifdef GEOFENCE_XARB_ZERO_FLAG_EN
  logic               res_zero;
`endif

  modport master (
    output req0, req1, lock0, lock1,
    output ax0, ay0, bx0, by0, ax1, ay1, bx1, by1,
    input  gnt0, gnt1, res_valid, res_id, res_value, res_pos
`ifdef GEOFENCE_XARB_ZERO_FLAG_EN
    , input res_zero
`endif
  );

  modport slave (
    input  req0, req1, lock0, lock1,
    input  ax0, ay0, bx0, by0, ax1, ay1, bx1, by1,
    output gnt0, gnt1, res_valid, res_id, res_value, res_pos
`ifdef GEOFENCE_XARB_ZERO_FLAG_EN
    , output res_zero
`endif
  );
endinterface

// File: rtl/geofence_xarb.sv
// Two-requester arbiter with lockable bursts feeding a 3-stage pipelined 2D cross product (ax*by - bx*ay).
// Optional res_zero output is enabled by defining GEOFENCE_XARB_ZERO_FLAG_EN.
module geofence_xarb #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  geofence_xarb_if.slave  bus
);
  localparam int unsigned OPW = 11;
  localparam int unsigned PRW = 22;
  localparam int unsigned RW  = 23;
  localparam int unsigned CW  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam bit            LOCK_EN   = (MAX_BURST > 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          rr_q, rr_d;      // last granted requester
  logic          gnt0_c, gnt1_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      rr_q    <= rr_d;
    end
  end

  // Grant selection and ownership tracking
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || rr_q)) gnt0_c = 1'b1;
        else if (bus.req1)                   gnt1_c = 1'b1;
        if (gnt0_c && bus.lock0 && LOCK_EN) begin
          state_d = OWN0;
          burst_d = CW'(1);
        end else if (gnt1_c && bus.lock1 && LOCK_EN) begin
          state_d = OWN1;
          burst_d = CW'(1);
        end
      end
      OWN0: begin
        gnt0_c = bus.req0;
        if (gnt0_c) begin
          burst_d = burst_q + CW'(1);
          if (!bus.lock0 || burst_d == BURST_MAX) begin
            state_d = IDLE;
            burst_d = '0;
          end
        end else if (!bus.lock0) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      OWN1: begin
        gnt1_c = bus.req1;
        if (gnt1_c) begin
          burst_d = burst_q + CW'(1);
          if (!bus.lock1 || burst_d == BURST_MAX) begin
            state_d = IDLE;
            burst_d = '0;
          end
        end else if (!bus.lock1) begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
    if (reset) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end
    if (gnt0_c)      rr_d = 1'b0;
    else if (gnt1_c) rr_d = 1'b1;
  end

  assign bus.gnt0 = gnt0_c;
  assign bus.gnt1 = gnt1_c;

  logic                  xfer_c;
  logic signed [OPW-1:0] ax_d, ay_d, bx_d, by_d;
  logic                  s0_valid_q, s0_id_q;
  logic signed [OPW-1:0] s0_ax_q, s0_ay_q, s0_bx_q, s0_by_q;
  logic signed [PRW-1:0] p1_d, p2_d;
  logic                  s1_valid_q, s1_id_q;
  logic signed [PRW-1:0] s1_p1_q, s1_p2_q;
  logic signed [RW-1:0]  diff_d;
  logic                  res_valid_q, res_id_q, res_pos_q;
  logic signed [RW-1:0]  res_value_q;

  assign xfer_c = gnt0_c | gnt1_c;
  assign ax_d   = gnt1_c ? bus.ax1 : bus.ax0;
  assign ay_d   = gnt1_c ? bus.ay1 : bus.ay0;
  assign bx_d   = gnt1_c ? bus.bx1 : bus.bx0;
  assign by_d   = gnt1_c ? bus.by1 : bus.by0;
  assign p1_d   = PRW'(s0_ax_q) * PRW'(s0_by_q);
  assign p2_d   = PRW'(s0_bx_q) * PRW'(s0_ay_q);
  assign diff_d = RW'(s1_p1_q) - RW'(s1_p2_q);

  // Operand capture, products, difference; data regs only load behind a valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid_q  <= 1'b0;
      s0_id_q     <= 1'b0;
      s0_ax_q     <= '0;
      s0_ay_q     <= '0;
      s0_bx_q     <= '0;
      s0_by_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_p1_q     <= '0;
      s1_p2_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_value_q <= '0;
      res_pos_q   <= 1'b0;
    end else begin
      s0_valid_q  <= xfer_c;
      s1_valid_q  <= s0_valid_q;
      res_valid_q <= s1_valid_q;
      if (xfer_c) begin
        s0_id_q <= gnt1_c;
        s0_ax_q <= ax_d;
        s0_ay_q <= ay_d;
        s0_bx_q <= bx_d;
        s0_by_q <= by_d;
      end
      if (s0_valid_q) begin
        s1_id_q <= s0_id_q;
        s1_p1_q <= p1_d;
        s1_p2_q <= p2_d;
      end
      if (s1_valid_q) begin
        res_id_q    <= s1_id_q;
        res_value_q <= diff_d;
        res_pos_q   <= (diff_d > 23'sd0);
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_value = res_value_q;
  assign bus.res_pos   = res_pos_q;

`ifdef GEOFENCE_XARB_ZERO_FLAG_EN
  logic res_zero_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           res_zero_q <= 1'b0;
    else if (s1_valid_q) res_zero_q <= (diff_d == '0);
  end

  assign bus.res_zero = res_zero_q;
`endif
endmodule

// File: tb/tb_geofence_xarb.sv
// Scoreboard bench for geofence_xarb: a rule-level arbiter/arithmetic model predicts grants and
// queues expected results, a negedge monitor pops and compares every emitted result.
module tb_geofence_xarb;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  geofence_xarb_if ifc();

  geofence_xarb #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int value;
    int due;
  } item_t;

  item_t sb[$];
  item_t it;

  // Reference model: current owner (-1 none), burst length so far, last granted requester
  int m_owner = -1;
  int m_burst = 0;
  int m_last  = 1;

  int hold_value = 0;
  int hold_id    = 0;
  int hold_pos   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_value = 0;
      hold_id    = 0;
      hold_pos   = 0;
    end else if (ifc.res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        it = sb.pop_front();
        chk("res_latency", cyc, it.due);
        chk("res_id", int'(ifc.res_id), it.id);
        chk("res_value", int'(ifc.res_value), it.value);
        chk("res_pos", int'(ifc.res_pos), int'(it.value > 0));
`ifdef GEOFENCE_XARB_ZERO_FLAG_EN
        chk("res_zero", int'(ifc.res_zero), int'(it.value == 0));
`endif
      end
      hold_value = int'(ifc.res_value);
      hold_id    = int'(ifc.res_id);
      hold_pos   = int'(ifc.res_pos);
    end else begin
      chk("hold_value", int'(ifc.res_value), hold_value);
      chk("hold_id", int'(ifc.res_id), hold_id);
      chk("hold_pos", int'(ifc.res_pos), hold_pos);
    end
  end

  // Called just after a negedge with inputs set; checks grants, records the transfer, advances to next negedge
  task automatic step(output int obs);
    int g, lk, ax, ay, bx, by;
    item_t e;
    #1;
    if (m_owner == 0)                g = ifc.req0 ? 0 : -1;
    else if (m_owner == 1)           g = ifc.req1 ? 1 : -1;
    else if (ifc.req0 && ifc.req1)   g = 1 - m_last;
    else if (ifc.req0)               g = 0;
    else if (ifc.req1)               g = 1;
    else                             g = -1;
    obs = ifc.gnt0 ? 0 : (ifc.gnt1 ? 1 : -1);
    chk("gnt0", int'(ifc.gnt0), int'(g == 0));
    chk("gnt1", int'(ifc.gnt1), int'(g == 1));
    if (g >= 0) begin
      ax = (g == 0) ? int'(ifc.ax0) : int'(ifc.ax1);
      ay = (g == 0) ? int'(ifc.ay0) : int'(ifc.ay1);
      bx = (g == 0) ? int'(ifc.bx0) : int'(ifc.bx1);
      by = (g == 0) ? int'(ifc.by0) : int'(ifc.by1);
      e.id = g;
      e.value = ax * by - bx * ay;
      e.due = cyc + 3;
      sb.push_back(e);
      m_last = g;
    end
    if (m_owner >= 0) begin
      lk = (m_owner == 0) ? int'(ifc.lock0) : int'(ifc.lock1);
      if (g == m_owner) begin
        m_burst++;
        if (lk == 0 || m_burst == MB) m_owner = -1;
      end else if (lk == 0) begin
        m_owner = -1;
      end
    end else if (g >= 0) begin
      lk = (g == 0) ? int'(ifc.lock0) : int'(ifc.lock1);
      if (lk != 0 && MB > 1) begin
        m_owner = g;
        m_burst = 1;
      end
    end
    if (m_owner < 0) m_burst = 0;
    @(negedge clk);
  endtask

  task automatic set_req(input logic r0, input logic l0, input logic r1, input logic l1);
    ifc.req0 = r0; ifc.lock0 = l0; ifc.req1 = r1; ifc.lock1 = l1;
  endtask

  task automatic set_ops0(input int ax, input int ay, input int bx, input int by);
    ifc.ax0 = 11'(ax); ifc.ay0 = 11'(ay); ifc.bx0 = 11'(bx); ifc.by0 = 11'(by);
  endtask

  task automatic set_ops1(input int ax, input int ay, input int bx, input int by);
    ifc.ax1 = 11'(ax); ifc.ay1 = 11'(ay); ifc.bx1 = 11'(bx); ifc.by1 = 11'(by);
  endtask

  task automatic rand_ops();
    ifc.ax0 = 11'($urandom); ifc.ay0 = 11'($urandom);
    ifc.bx0 = 11'($urandom); ifc.by0 = 11'($urandom);
    ifc.ax1 = 11'($urandom); ifc.ay1 = 11'($urandom);
    ifc.bx1 = 11'($urandom); ifc.by1 = 11'($urandom);
  endtask

  // Entered just after a negedge; leaves just after a negedge with reset released
  task automatic do_reset();
    #2;
    reset = 1'b1;
    sb.delete();
    m_owner = -1;
    m_burst = 0;
    m_last  = 1;
    set_req(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rst_gnt0", int'(ifc.gnt0), 0);
    chk("rst_gnt1", int'(ifc.gnt1), 0);
    chk("rst_res_valid", int'(ifc.res_valid), 0);
    chk("rst_res_id", int'(ifc.res_id), 0);
    chk("rst_res_value", int'(ifc.res_value), 0);
    chk("rst_res_pos", int'(ifc.res_pos), 0);
`ifdef GEOFENCE_XARB_ZERO_FLAG_EN
    chk("rst_res_zero", int'(ifc.res_zero), 0);
`endif
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    int g;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(g);
  endtask

  initial begin
    int g;
    int pat[6];
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    set_ops0(0, 0, 0, 0);
    set_ops1(0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Single request, result -26 after two cycles
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    set_ops0(3, 4, 5, -2);
    step(g);
    chk("single_gnt", g, 0);
    idle(4);

    // Both requesting without lock alternate from reset
    do_reset();
    set_ops0(7, -3, 2, 9);
    set_ops1(-5, 6, 11, -1);
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(g);
      chk("rr_alternate", g, i % 2);
    end
    idle(4);

    // Locked burst of MB grants, then the other requester, then back
    do_reset();
    pat = '{0, 0, 0, 0, 1, 0};
    set_req(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(g);
      chk("burst_pattern", g, pat[i]);
    end
    idle(4);

    // OWN1 blocks req0 until lock1 drops with req1 low
    do_reset();
    set_req(1'b0, 1'b0, 1'b1, 1'b1);
    step(g);
    chk("own1_enter", g, 1);
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    step(g);
    chk("own1_block", g, -1);
    step(g);
    chk("own1_release", g, 0);
    idle(4);

    // Arithmetic extremes
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    set_ops0(-1024, -1024, 1023, 1023);
    step(g);
    set_ops0(1023, -1024, -1024, 1023);
    step(g);
    set_ops0(-1024, 1023, 1023, -1024);
    step(g);
    idle(4);

    // Reset one cycle after a transfer discards it; first tie then goes to req0
    do_reset();
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    step(g);
    chk("pre_reset_gnt", g, 0);
    do_reset();
    idle(5);
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    step(g);
    chk("post_reset_tie", g, 0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      rand_ops();
      step(g);
    end
    idle(5);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/geofence_xarb.md
GEOFENCE_XARB -- requirements
Module: geofence_xarb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, maximum consecutive locked grants to one requester (legal 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1 each  operation request from requester 0 (vertex sorter) and requester 1 (inside tester).
REQ-005 SHALL have ports lock0/lock1  input  1 each  requester wants to keep ownership after this transfer.
REQ-006 SHALL have ports ax0, ay0, bx0, by0, ax1, ay1, bx1, by1  input  11 each, signed two's complement  vector operands per requester.
REQ-007 SHALL have ports gnt0/gnt1  output  1 each  combinational grant; a transfer occurs on a rising edge where reqN && gntN.
REQ-008 SHALL have ports res_valid  output  1; res_id  output  1  requester of the result; res_value  output  23 signed  ax*by - bx*ay; res_pos  output  1  res_value > 0.

Function
REQ-009 gnt0 and gnt1 SHALL never be high in the same cycle, and gntN SHALL be low whenever reqN is low.
REQ-010 The FSM SHALL have the states IDLE, OWN0 and OWN1.
REQ-011 In IDLE, a single requester SHALL be granted; with both requesting, the requester not granted most recently SHALL win (round-robin pointer).
REQ-012 The round-robin pointer SHALL be updated to the granted requester on every transfer, in every state.
REQ-013 On an IDLE transfer by N with lockN=1 and MAX_BURST>1, the FSM SHALL go to OWNN with burst count 1; with lockN=0 it SHALL remain in IDLE.
REQ-014 In OWNN, only N SHALL be grantable, and the other requester SHALL be blocked even if N is not requesting.
REQ-015 Each transfer in OWNN SHALL increment the burst count.
REQ-016 OWNN SHALL return to IDLE after a transfer with lockN=0, after the transfer that makes the burst count equal MAX_BURST, or on any cycle with lockN=0 and no transfer.
REQ-017 Operands of the granted requester SHALL be registered at transfer (stage 0).
REQ-018 Both 22-bit signed products SHALL be registered at stage 1.
REQ-019 The 23-bit signed difference SHALL be registered at stage 2, giving res_valid exactly 2 cycles after the transfer edge.
REQ-020 Throughput SHALL be one result per cycle; results SHALL emerge in transfer order, each with its matching res_id.
REQ-021 Arithmetic SHALL be exact (no overflow): operand range -1024..1023 gives |result| ≤ 2^21.
REQ-022 res_valid SHALL be a one-cycle pulse per transfer, with no backpressure.
REQ-023 res_value, res_id and res_pos SHALL hold their last value when res_valid=0.

Reset
REQ-024 Reset SHALL force the state to IDLE, clear the burst count, set the pointer so req0 wins the first tie, and clear the pipeline valid bits.
REQ-025 Reset SHALL drive res_valid=0, res_id=0, res_value=0 and res_pos=0; gnt0 and gnt1 are 0 while reset is asserted.
REQ-026 Reset asserted mid-burst or mid-pipeline SHALL discard all in-flight operations, with no result emitted after reset release.

Configuration
REQ-027 When macro GEOFENCE_XARB_ZERO_FLAG_EN is defined, output res_zero (1 bit, high iff res_value==0, reset 0, registered with res_value) SHALL exist.
REQ-028 When GEOFENCE_XARB_ZERO_FLAG_EN is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL cover: req0 alone, a=(3,4), b=(5,-2), lock0=0 -> gnt0 same cycle; 2 cycles later res_valid=1, res_id=0, res_value=-26, res_pos=0.
REQ-030 Bench SHALL cover: req0 and req1 held high, locks 0, out of reset -> grants alternate 0,1,0,1 and results alternate id 0,1,0,1 with one result per cycle.
REQ-031 Bench SHALL cover: req0 and lock0 held high, req1 high, MAX_BURST=4 -> gnt0 for 4 consecutive cycles, then gnt1 for 1 cycle, then gnt0 again.
REQ-032 Bench SHALL cover: in OWN1, lock1 dropped with req1=0 while req0=1 -> gnt0 on the next cycle.
REQ-033 Bench SHALL cover: operands (-1024,-1024),(1023,1023) -> res_value=0 (res_zero=1 with the macro); a=(1023,-1024), b=(-1024,1023) -> res_value=1046529-1048576=-2047.
REQ-034 Bench SHALL cover: reset asserted 1 cycle after a transfer -> no res_valid pulse after release; the first tie afterwards goes to req0.
